retire_trace_unit: RTL

// - Debug shadow pipeline carrying per-instruction {valid, pc, ctrl, mispred} from EX to WB, in step with the core's EX/MEM and MEM/WB registers.
// - Produces the retirement-aligned o_insn_vld / o_pc_debug / o_ctrl / o_mispred consumed by the ISA-test scoreboard.
// - Also keeps saturating performance counters, a halt detector and a no-retire watchdog, so benches get these without reconstructing them.

---
 rtl/retire_trace_unit_if.sv | 36 +++
 rtl/retire_trace_unit.sv | 128 ++++++++++++
 2 files changed

// File: rtl/retire_trace_unit_if.sv
// Retirement trace bus: EX-side instruction info in, retirement/perf/status out.
// The master side (core or bench) drives the i_* signals; the slave side (the trace unit) drives the o_* signals.
interface retire_trace_unit_if #(
  parameter int unsigned CNT_W = 32
);
  logic             i_stall;
  logic             i_ex_vld;
  logic [31:0]      i_ex_pc;
  logic             i_ex_ctrl;
  logic             i_ex_mispred;

  logic             o_insn_vld;
  logic [31:0]      o_pc_debug;
  logic             o_ctrl;
  logic             o_mispred;
  logic [CNT_W-1:0] o_cnt_cycle;
  logic [CNT_W-1:0] o_cnt_insn;
  logic [CNT_W-1:0] o_cnt_ctrl;
  logic [CNT_W-1:0] o_cnt_mispred;
  logic             o_halt;
  logic             o_timeout;

  modport master (
    output i_stall, i_ex_vld, i_ex_pc, i_ex_ctrl, i_ex_mispred,
    input  o_insn_vld, o_pc_debug, o_ctrl, o_mispred,
    input  o_cnt_cycle, o_cnt_insn, o_cnt_ctrl, o_cnt_mispred,
    input  o_halt, o_timeout
  );

  modport slave (
    input  i_stall, i_ex_vld, i_ex_pc, i_ex_ctrl, i_ex_mispred,
    output o_insn_vld, o_pc_debug, o_ctrl, o_mispred,
    output o_cnt_cycle, o_cnt_insn, o_cnt_ctrl, o_cnt_mispred,
    output o_halt, o_timeout
  );
endinterface

// File: rtl/retire_trace_unit.sv
// Debug shadow pipeline from EX to retirement, with saturating perf counters,
// halt-PC detection and a no-retire watchdog.
module retire_trace_unit #(
  parameter int unsigned DEPTH   = 2,
  parameter int unsigned CNT_W   = 32,
  parameter logic [31:0] HALT_PC = 32'h1c,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  retire_trace_unit_if.slave   bus
);

  typedef struct packed {
    logic        vld;
    logic [31:0] pc;
    logic        ctrl;
    logic        mispred;
  } stage_t;

  localparam int unsigned SW     = $bits(stage_t);
  localparam int unsigned PIPE_W = DEPTH * SW;
  localparam int unsigned WD_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  // Stage 0 lives in the low SW bits; the last (retiring) stage in the top SW bits.
  logic [PIPE_W-1:0] pipe_q, pipe_d;
  logic [CNT_W-1:0]  cnt_cycle_q, cnt_cycle_d;
  logic [CNT_W-1:0]  cnt_insn_q, cnt_insn_d;
  logic [CNT_W-1:0]  cnt_ctrl_q, cnt_ctrl_d;
  logic [CNT_W-1:0]  cnt_mispred_q, cnt_mispred_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              halt_q, halt_d;
  logic              timeout_q, timeout_d;

  stage_t ex_entry;
  stage_t last;
  logic   retire;
  logic   live;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != '1)) ? v + CNT_W'(1) : v;
  endfunction

  // Mispredict is only meaningful on a valid control instruction.
  always_comb begin
    ex_entry.vld     = bus.i_ex_vld;
    ex_entry.pc      = bus.i_ex_pc;
    ex_entry.ctrl    = bus.i_ex_ctrl & bus.i_ex_vld;
    ex_entry.mispred = bus.i_ex_mispred & bus.i_ex_ctrl & bus.i_ex_vld;
  end

  assign last = pipe_q[PIPE_W-1 -: SW];

  always_comb begin
    pipe_d        = pipe_q;
    cnt_cycle_d   = cnt_cycle_q;
    cnt_insn_d    = cnt_insn_q;
    cnt_ctrl_d    = cnt_ctrl_q;
    cnt_mispred_d = cnt_mispred_q;
    wd_d          = wd_q;
    halt_d        = halt_q;
    timeout_d     = timeout_q;

    live   = ~halt_q & ~timeout_q;
    retire = last.vld & ~bus.i_stall & live;

    // Shift in the new EX entry; the old last stage falls off the top.
    if (!bus.i_stall) begin
      pipe_d = PIPE_W'({pipe_q, ex_entry});
    end

    if (live) begin
      cnt_cycle_d   = sat_inc(cnt_cycle_q, 1'b1);
      cnt_insn_d    = sat_inc(cnt_insn_q, retire);
      cnt_ctrl_d    = sat_inc(cnt_ctrl_q, retire & last.ctrl);
      cnt_mispred_d = sat_inc(cnt_mispred_q, retire & last.mispred);
    end

    if (retire && (last.pc == HALT_PC)) begin
      halt_d = 1'b1;
    end

    // A halt needs a retirement, which also clears the watchdog, so halt beats timeout.
    if (live) begin
      if (retire) begin
        wd_d = '0;
      end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
        timeout_d = 1'b1;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pipe_q        <= '0;
      cnt_cycle_q   <= '0;
      cnt_insn_q    <= '0;
      cnt_ctrl_q    <= '0;
      cnt_mispred_q <= '0;
      wd_q          <= '0;
      halt_q        <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      pipe_q        <= pipe_d;
      cnt_cycle_q   <= cnt_cycle_d;
      cnt_insn_q    <= cnt_insn_d;
      cnt_ctrl_q    <= cnt_ctrl_d;
      cnt_mispred_q <= cnt_mispred_d;
      wd_q          <= wd_d;
      halt_q        <= halt_d;
      timeout_q     <= timeout_d;
    end
  end

  assign bus.o_insn_vld    = retire;
  assign bus.o_ctrl        = retire & last.ctrl;
  assign bus.o_mispred     = retire & last.mispred;
  assign bus.o_pc_debug    = last.pc;
  assign bus.o_cnt_cycle   = cnt_cycle_q;
  assign bus.o_cnt_insn    = cnt_insn_q;
  assign bus.o_cnt_ctrl    = cnt_ctrl_q;
  assign bus.o_cnt_mispred = cnt_mispred_q;
  assign bus.o_halt        = halt_q;
  assign bus.o_timeout     = timeout_q;

endmodule
